// File: rtl/multireceive.sv
// Receiving end of the keylock digit link: synchronises the three data wires and
// the strobe, filters short strobes, and packs DIGITS 3-bit digits into a code word.
module multireceive #(
  parameter int DIGITS       = 6,
  parameter int SAMPLE_DELAY = 600000,
  parameter int TIMEOUT      = 6000000
) (
  input  logic                  hwclk,
  input  logic                  rst_n,
  input  logic                  in0,
  input  logic                  in1,
  input  logic                  in2,
  input  logic                  controlIn,
  output logic [3*DIGITS-1:0]   code,
  output logic                  valid,
  output logic                  err,
  output logic                  busy,
  output logic [2:0]            count
);

  localparam int MAXC = (SAMPLE_DELAY > TIMEOUT) ? SAMPLE_DELAY : TIMEOUT;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(SAMPLE_DELAY - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HIGH    = 2'd1,
    RELEASE = 2'd2,
    GAP     = 2'd3
  } state_t;

  state_t                state_r;
  logic [3:0]            sync1_r;
  logic [3:0]            sync2_r;
  logic [CW-1:0]         hold_r;
  logic [CW-1:0]         wait_r;
  logic [3*DIGITS-1:0]   shreg_r;
  logic                  ctl_s;
  logic [2:0]            data_s;
  logic                  hold_done_s;
  logic                  timeout_s;
  logic                  last_s;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + CW'(1);
  endfunction

  assign ctl_s       = sync2_r[3];
  assign data_s      = sync2_r[2:0];
  assign hold_done_s = (hold_r >= HOLD_LAST);
  assign timeout_s   = (wait_r >= WAIT_LAST);
  assign last_s      = (count == 3'(DIGITS));

  // Two-flop synchronisers for the asynchronous link wires
  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 4'd0;
      sync2_r <= 4'd0;
    end else begin
      sync1_r <= {controlIn, in2, in1, in0};
      sync2_r <= sync1_r;
    end
  end

  // Frame reassembly FSM with strobe filter and inter-digit timeout
  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      hold_r  <= '0;
      wait_r  <= '0;
      shreg_r <= '0;
      code    <= '0;
      valid   <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
      count   <= 3'd0;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      case (state_r)
        IDLE: begin
          hold_r <= '0;
          wait_r <= '0;
          if (ctl_s) begin
            shreg_r <= '0;
            state_r <= HIGH;
          end else begin
            state_r <= IDLE;
          end
        end
        HIGH: begin
          if (!ctl_s) begin
            // strobe too short: drop it and go back to where the high began
            hold_r  <= '0;
            wait_r  <= '0;
            state_r <= busy ? GAP : IDLE;
          end else if (hold_done_s) begin
            for (int k = 0; k < DIGITS; k++) begin
              if (count == 3'(k)) shreg_r[3*k +: 3] <= data_s;
            end
            count   <= count + 3'd1;
            busy    <= 1'b1;
            hold_r  <= '0;
            wait_r  <= '0;
            state_r <= RELEASE;
          end else if (busy && timeout_s) begin
            err     <= 1'b1;
            count   <= 3'd0;
            busy    <= 1'b0;
            hold_r  <= '0;
            wait_r  <= '0;
            state_r <= IDLE;
          end else begin
            hold_r <= sat_inc(hold_r);
            wait_r <= busy ? sat_inc(wait_r) : '0;
          end
        end
        RELEASE: begin
          if (!ctl_s) begin
            wait_r <= '0;
            if (last_s) begin
              code    <= shreg_r;
              valid   <= 1'b1;
              count   <= 3'd0;
              busy    <= 1'b0;
              state_r <= IDLE;
            end else begin
              state_r <= GAP;
            end
          end else if (timeout_s) begin
            err     <= 1'b1;
            count   <= 3'd0;
            busy    <= 1'b0;
            wait_r  <= '0;
            state_r <= IDLE;
          end else begin
            wait_r <= sat_inc(wait_r);
          end
        end
        GAP: begin
          if (ctl_s) begin
            hold_r  <= '0;
            wait_r  <= '0;
            state_r <= HIGH;
          end else if (timeout_s) begin
            err     <= 1'b1;
            count   <= 3'd0;
            busy    <= 1'b0;
            wait_r  <= '0;
            state_r <= IDLE;
          end else begin
            wait_r <= sat_inc(wait_r);
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
